// File: rtl/spi_pkg.sv
// Shared constants and FSM state encoding for the SPI transfer controller.
package spi_pkg;

    localparam int DATA_WITH = 8;
    localparam int DVSR_W    = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SS_SETUP,
        ST_LOAD,
        ST_WAIT_DONE,
        ST_SS_HOLD
    } state_t;

endpackage

// File: rtl/spi_sync_fifo.sv
// Single-clock FIFO used for the TX and RX byte queues of spi_xfer_ctrl.
module spi_sync_fifo
    import spi_pkg::*;
#(
    parameter int DATA_WITH  = spi_pkg::DATA_WITH,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_push,
    input  logic [DATA_WITH-1:0] i_wdata,
    input  logic                 i_pop,
    output logic [DATA_WITH-1:0] o_rdata,
    output logic                 o_full,
    output logic                 o_empty
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [DATA_WITH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wptr;
    logic [PTR_W-1:0]     r_rptr;
    logic [PTR_W:0]       r_count;
    logic                 w_push;
    logic                 w_pop;

    assign o_full  = (r_count == (PTR_W+1)'(FIFO_DEPTH));
    assign o_empty = (r_count == '0);
    assign o_rdata = r_mem[r_rptr];

    // A full FIFO still accepts a write when a read frees a slot in the same cycle.
    assign w_pop  = i_pop & ~o_empty;
    assign w_push = i_push & (~o_full | w_pop);

    always_ff @(posedge i_clk) begin
        if (w_push)
            r_mem[r_wptr] <= i_wdata;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)
                r_rptr <= r_rptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/spi_xfer_ctrl.sv
// Multi-byte SPI transaction sequencer: slave select, setup/hold delays, TX/RX queues.
// Build option SPI_XFER_RX_CAPTURE_EN adds the RX FIFO and overflow flag.
module spi_xfer_ctrl
    import spi_pkg::*;
#(
    parameter int  DATA_WITH  = spi_pkg::DATA_WITH,
    parameter int  FIFO_DEPTH = 4,
    parameter int  NUM_SS     = 2,
    localparam int SS_W       = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_cmd_valid,
    output logic                       o_cmd_ready,
    input  logic [7:0]                 i_cmd_len,
    input  logic [SS_W-1:0]            i_cmd_ss,
    input  logic [spi_pkg::DVSR_W-1:0] i_dvsr,
    input  logic [DATA_WITH-1:0]       i_tx_data,
    input  logic                       i_tx_valid,
    output logic                       o_tx_ready,
    output logic [DATA_WITH-1:0]       o_rx_data,
    output logic                       o_rx_valid,
    input  logic                       i_rx_ready,
    output logic                       o_rx_overflow,
    output logic                       o_xfer_done_tick,
    output logic [NUM_SS-1:0]          o_ss_n,
    output logic [DATA_WITH-1:0]       o_core_din,
    output logic                       o_core_start,
    input  logic                       i_core_ready,
    input  logic                       i_core_done_tick,
    input  logic [DATA_WITH-1:0]       i_core_dout
);

    state_t               r_state;
    logic [7:0]           r_len;
    logic [DVSR_W-1:0]    r_dly;
    logic [NUM_SS-1:0]    r_ss_n;
    logic                 r_core_start;
    logic [DATA_WITH-1:0] r_core_din;
    logic                 r_done_tick;

    logic [NUM_SS-1:0]    w_ss_sel_n;
    logic                 w_tx_full;
    logic                 w_tx_empty;
    logic [DATA_WITH-1:0] w_tx_head;
    logic                 w_tx_pop;

    always_comb begin
        w_ss_sel_n = '1;
        for (int i = 0; i < NUM_SS; i++)
            w_ss_sel_n[i] = (i_cmd_ss != SS_W'(i));
    end

    assign w_tx_pop = (r_state == ST_LOAD) & ~w_tx_empty & i_core_ready;

    spi_sync_fifo #(
        .DATA_WITH  (DATA_WITH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (i_tx_valid),
        .i_wdata (i_tx_data),
        .i_pop   (w_tx_pop),
        .o_rdata (w_tx_head),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_len        <= '0;
            r_dly        <= '0;
            r_ss_n       <= '1;
            r_core_start <= 1'b0;
            r_core_din   <= '0;
            r_done_tick  <= 1'b0;
        end else begin
            r_core_start <= 1'b0;
            r_done_tick  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_cmd_valid) begin
                        r_len   <= i_cmd_len;
                        r_ss_n  <= w_ss_sel_n;
                        r_dly   <= '0;
                        r_state <= ST_SS_SETUP;
                    end
                end
                ST_SS_SETUP: begin
                    if (r_dly == i_dvsr)
                        r_state <= ST_LOAD;
                    else
                        r_dly <= r_dly + DVSR_W'(1);
                end
                ST_LOAD: begin
                    // Start and byte leave together on the first WAIT_DONE cycle.
                    if (w_tx_pop) begin
                        r_core_start <= 1'b1;
                        r_core_din   <= w_tx_head;
                        r_state      <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (i_core_done_tick) begin
                        if (r_len == 8'd0) begin
                            r_dly   <= '0;
                            r_state <= ST_SS_HOLD;
                        end else begin
                            r_len   <= r_len - 8'd1;
                            r_state <= ST_LOAD;
                        end
                    end
                end
                ST_SS_HOLD: begin
                    if (r_dly == i_dvsr) begin
                        r_ss_n      <= '1;
                        r_done_tick <= 1'b1;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_dly <= r_dly + DVSR_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_cmd_ready      = (r_state == ST_IDLE);
    assign o_tx_ready       = ~w_tx_full;
    assign o_ss_n           = r_ss_n;
    assign o_core_start     = r_core_start;
    assign o_core_din       = r_core_din;
    assign o_xfer_done_tick = r_done_tick;

`ifdef SPI_XFER_RX_CAPTURE_EN
    logic w_rx_push;
    logic w_rx_full;
    logic w_rx_empty;
    logic r_rx_overflow;

    // Done ticks outside WAIT_DONE (e.g. a byte orphaned by reset) are not captured.
    assign w_rx_push = (r_state == ST_WAIT_DONE) & i_core_done_tick;

    spi_sync_fifo #(
        .DATA_WITH  (DATA_WITH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (w_rx_push),
        .i_wdata (i_core_dout),
        .i_pop   (i_rx_ready),
        .o_rdata (o_rx_data),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_rx_overflow <= 1'b0;
        else if (w_rx_push & w_rx_full & ~i_rx_ready)
            r_rx_overflow <= 1'b1;
    end

    assign o_rx_valid    = ~w_rx_empty;
    assign o_rx_overflow = r_rx_overflow;
`else
    logic w_unused;
    assign w_unused      = ^{i_core_dout, i_rx_ready};
    assign o_rx_data     = '0;
    assign o_rx_valid    = 1'b0;
    assign o_rx_overflow = 1'b0;
`endif

endmodule

// File: doc/spi_xfer_ctrl.md
SPI_XFER_CTRL -- requirements
Module: spi_xfer_ctrl

Interface
REQ-001 Parameter DATA_WITH, default 8: byte width shared with the SPI byte engine.
REQ-002 Parameter FIFO_DEPTH, default 4: entries in each of the TX and RX FIFOs; power of two, at least 2.
REQ-003 Parameter NUM_SS, default 2: number of active-low slave-select lines.
REQ-004 Ports:
- clk  in  1  sole clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- cmd_valid  in  1  transaction request.
- cmd_ready  out  1  high only in IDLE.
- cmd_len  in  8  byte count minus 1 (1..256 bytes).
- cmd_ss  in  $clog2(NUM_SS)  slave index.
- dvsr  in  16  select setup/hold delay in clocks, minus 1.
- tx_data  in  DATA_WITH  TX FIFO write data.
- tx_valid  in  1  TX push request.
- tx_ready  out  1  TX FIFO not full.
- rx_data  out  DATA_WITH  RX FIFO head.
- rx_valid  out  1  RX FIFO not empty.
- rx_ready  in  1  RX pop request.
- rx_overflow  out  1  sticky; a received byte was dropped.
- xfer_done_tick  out  1  one-cycle pulse at end of transaction.
- ss_n  out  NUM_SS  slave selects, active-low.
- core_din  out  DATA_WITH  byte to the engine.
- core_start  out  1  one-cycle start pulse to the engine.
- core_ready  in  1  engine idle.
- core_done_tick  in  1  engine byte complete.
- core_dout  in  DATA_WITH  engine received byte.

Function
REQ-005 States: IDLE, SS_SETUP, LOAD, WAIT_DONE, SS_HOLD.
REQ-006 In IDLE, cmd_valid is accepted on the first cycle it is high. Acceptance latches cmd_len into the remaining-byte counter and cmd_ss into the select register, then moves to SS_SETUP.
REQ-007 ss_n[cmd_ss] is low from the first cycle after acceptance through the last SS_HOLD cycle. All other bits stay high. ss_n is registered.
REQ-008 SS_SETUP and SS_HOLD each last exactly dvsr+1 cycles, counted by a 16-bit counter cleared on entry. dvsr is sampled live.
REQ-009 LOAD, when the TX FIFO is non-empty and core_ready=1:
- core_start pulses for one cycle, with core_din = TX head in the same cycle;
- the TX FIFO pops;
- the state moves to WAIT_DONE.
Otherwise LOAD holds, so an empty TX FIFO stalls with ss_n still asserted.
REQ-010 WAIT_DONE on core_done_tick:
- core_dout is pushed to the RX FIFO;
- if the RX FIFO is full and rx_ready is not popping in that cycle, the byte is dropped and rx_overflow is set.
If the remaining count is 0, go to SS_HOLD; otherwise decrement and return to LOAD.
REQ-011 Leaving SS_HOLD: ss_n returns to all-ones, xfer_done_tick pulses for one cycle, and the state returns to IDLE. A new command is accepted no earlier than the following cycle.
REQ-012 FIFOs:
- tx_ready = ~tx_full.
- A push when full is ignored; a pop when empty is ignored.
- Simultaneous push and pop on a non-empty, non-full FIFO leaves the count unchanged.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally.
REQ-013 rx_overflow clears only on reset.
REQ-014 TX pushes are allowed in any state, including before the command is accepted.

Reset
REQ-015 While reset=1, at every clock edge:
- state becomes IDLE;
- ss_n becomes all-ones;
- core_start=0, xfer_done_tick=0, rx_overflow=0;
- both FIFOs become empty (tx_ready=1, rx_valid=0);
- counters become 0 and core_din becomes 0.
REQ-016 Reset mid-transaction deasserts ss_n on the cycle after the reset edge. Any byte already in flight in the engine is discarded; a core_done_tick arriving after reset is ignored in IDLE.

Configuration
REQ-017 Macro SPI_XFER_RX_CAPTURE_EN.
- Defined: RX FIFO and rx_overflow are built as specified.
- Undefined: no RX FIFO is instantiated and core_dout is ignored (write-only transfers); rx_valid=0, rx_data=0, rx_overflow=0 constantly.

Structure
REQ-018 A shared package spi_pkg holds:
- the state encoding typedef (5 states);
- the default width constants DATA_WITH=8 and DVSR_W=16.
REQ-019 One sub-module, spi_sync_fifo (parameters DATA_WITH, FIFO_DEPTH), is instantiated for TX and, when the macro is defined, for RX.

Verification
REQ-020 Single byte: cmd_len=0, cmd_ss=1, dvsr=3, TX=0xA5, loopback core_dout=core_din.
- ss_n=2'b01 for 4 setup cycles, then one core_start with core_din=0xA5.
- After done: 4 hold cycles, then one xfer_done_tick; rx_data=0xA5.
REQ-021 Burst of 3: cmd_len=2, TX 0x11,0x22,0x33 preloaded.
- Exactly three core_start pulses, in order, with no ss_n deassertion between bytes.
- rx_valid after the first byte; RX holds 3 entries at the end.
REQ-022 TX starvation: cmd_len=1 with one byte queued. The controller stalls in LOAD with ss_n low until a second byte is pushed 20 cycles later, then completes.
REQ-023 RX overflow: FIFO_DEPTH=4, cmd_len=5, rx_ready=0. rx_overflow rises on the 5th done tick; RX keeps the first 4 bytes.
REQ-024 Reset mid-burst: reset asserted in WAIT_DONE.
- Next cycle: ss_n all-ones, tx_ready=1, rx_valid=0, cmd_ready=1.
- A late core_done_tick causes no RX push.
REQ-025 Full/wrap: 10 push-then-pop passes through a depth-4 TX FIFO give in-order data across pointer wrap. A push while full is ignored.
